pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter NSTAGES, default 5: pipeline stages (IF..WB); NSTAGES-1 pipeline registers, index k = register after stage k (0=IFID, 1=IDEX, 2=EXMEM, 3=MEMWB).
REQ-002 SHALL have parameter BR_STAGE, default 3: stage resolving branches (3 = MEM); legal range 2..NSTAGES-2.
REQ-003 SHALL have parameter REGW, default 5: register-index width.
REQ-004 SHALL have parameter CNTW, default 16: statistics counter width.
REQ-005 SHALL have ports in this order:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- i_imiss  in  1  instruction-cache miss
- i_dmiss  in  1  data-cache miss
- i_branch_taken  in  1  taken branch in stage BR_STAGE
- i_idex_memread  in  1  IDEX instruction is a load
- i_idex_rt  in  REGW  IDEX load destination
- i_ifid_rs, i_ifid_rt  in  REGW each  IFID source registers
- o_pc_en  out  1  PC register update enable
- o_en  out  NSTAGES-1  per-register load enable
- o_valid  out  NSTAGES-1  per-register valid (0 = bubble)
- o_state  out  2  FSM state
- o_istall_cnt, o_dstall_cnt, o_luse_cnt  out  CNTW each  stall statistics

Function
REQ-006 SHALL implement FSM RUN=0, ISTALL=1, DSTALL=2, LUSE=3; o_state = current state.
REQ-007 SHALL compute next state each cycle with priority dmiss > branch > imiss > load-use: i_dmiss→DSTALL; else branch (i_branch_taken & o_valid[BR_STAGE-1])→RUN; else i_imiss→ISTALL; else load-use→LUSE; else RUN.
REQ-008 SHALL define load-use = o_valid[1] & o_valid[0] & i_idex_memread & i_idex_rt!=0 & (i_idex_rt==i_ifid_rs | i_idex_rt==i_ifid_rt).
REQ-009 SHALL, when i_dmiss=1, drive o_pc_en=0, o_en=0 and hold all o_valid.
REQ-010 SHALL, on branch (no dmiss), drive o_pc_en=1, o_en all 1, and next cycle clear o_valid[0..BR_STAGE-1]; o_valid[BR_STAGE..] shift normally.
REQ-011 SHALL, on imiss (no dmiss, no branch), drive o_pc_en=0, o_en all 1, load o_valid[0]<=0, shift o_valid[k]<=o_valid[k-1] for k>=1.
REQ-012 SHALL, on load-use (no higher-priority event), drive o_pc_en=0, o_en[0]=0 (hold IFID and o_valid[0]), o_en[k>=1]=1, o_valid[1]<=0, shift k>=2.
REQ-013 SHALL otherwise drive o_pc_en=1, o_en all 1, o_valid[0]<=1, shift k>=1.
REQ-014 SHALL make o_pc_en and o_en combinational from inputs and registered o_valid; o_valid and o_state registered, latency one cycle.
REQ-015 SHALL let a load-use persisting under stall re-evaluate each cycle; LUSE lasts exactly one cycle per hazard because o_valid[1] becomes 0.
REQ-016 SHALL increment per cycle: o_dstall_cnt when i_dmiss; o_istall_cnt when imiss rule applies; o_luse_cnt when load-use rule applies; counters saturate at 2^CNTW-1.

Reset
REQ-017 SHALL, on rising clk with rst=1, set o_valid=0, state RUN, all counters 0.
REQ-018 SHALL drive o_pc_en=0 and o_en=0 while rst=1, regardless of other inputs.
REQ-019 SHALL discard any in-progress stall on reset; first cycle after rst deasserts evaluates REQ-007 afresh.

Configuration
REQ-020 SHALL compile counter logic only when PIPE_HAZARD_STALL_CNT_EN is defined; without it, o_istall_cnt, o_dstall_cnt, o_luse_cnt are constant 0 and no counter flops exist; FSM behaviour identical either way.

Verification
REQ-021 SHALL test reset fill: rst 1 cycle, no events -> o_valid 0000,0001,0011,0111,1111 on successive cycles, o_pc_en=1.
REQ-022 SHALL test dmiss: full pipe, i_dmiss=1 for 3 cycles -> o_pc_en=0, o_en=0000, o_valid=1111 held, o_state=2, o_dstall_cnt=3.
REQ-023 SHALL test imiss: full pipe, i_imiss=1 for 2 cycles -> o_valid 1110 then 1100, o_pc_en=0, o_istall_cnt=2.
REQ-024 SHALL test load-use: o_valid=1111, memread=1, rt=5, ifid_rs=5 -> o_en=1110, o_pc_en=0, next o_valid=1101, state LUSE; rt=0 -> no stall.
REQ-025 SHALL test branch vs imiss: o_valid=1111, i_branch_taken=1 and i_imiss=1 -> o_pc_en=1, next o_valid=1000; with i_dmiss=1 too -> branch ignored, valids held.
REQ-026 SHALL test saturation (CNTW=2): i_dmiss held 6 cycles -> o_dstall_cnt=3; without PIPE_HAZARD_STALL_CNT_EN -> 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard/stall controller for an in-order pipeline of NSTAGES stages with
//   NSTAGES-1 pipeline registers. Register k sits after stage k, so for the
//   default depth 0=IFID, 1=IDEX, 2=EXMEM and 3=MEMWB.
//
//   Events are handled in priority order: dmiss > taken branch > imiss >
//   load-use.
//     - dmiss freezes the whole pipe.
//     - A taken branch flushes the registers younger than BR_STAGE.
//     - imiss injects a bubble at IFID.
//     - load-use holds IFID and injects a bubble at IDEX.
//
//   Optional feature: define PIPE_HAZARD_STALL_CNT_EN to build saturating
//   stall counters. Without it the counter outputs are tied to 0.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   i_imiss, i_dmiss            I$/D$ miss
//   i_branch_taken              taken branch resolving in stage BR_STAGE
//   i_idex_memread, i_idex_rt   IDEX load and its destination register
//   i_ifid_rs, i_ifid_rt        IFID source registers
//   o_pc_en, o_en               PC / per-register load enables (combinational)
//   o_valid                     per-register valid, 0 = bubble (registered)
//   o_state                     FSM state: RUN/ISTALL/DSTALL/LUSE
//   o_*_cnt                     stall statistics
module pipe_hazard_ctrl #(
  parameter int NSTAGES  = 5,
  parameter int BR_STAGE = 3,
  parameter int REGW     = 5,
  parameter int CNTW     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_imiss,
  input  logic               i_dmiss,
  input  logic               i_branch_taken,
  input  logic               i_idex_memread,
  input  logic [REGW-1:0]    i_idex_rt,
  input  logic [REGW-1:0]    i_ifid_rs,
  input  logic [REGW-1:0]    i_ifid_rt,
  output logic               o_pc_en,
  output logic [NSTAGES-2:0] o_en,
  output logic [NSTAGES-2:0] o_valid,
  output logic [1:0]         o_state,
  output logic [CNTW-1:0]    o_istall_cnt,
  output logic [CNTW-1:0]    o_dstall_cnt,
  output logic [CNTW-1:0]    o_luse_cnt
);

  localparam int NR = NSTAGES - 1;

  typedef enum logic [1:0] {RUN = 2'd0, ISTALL = 2'd1, DSTALL = 2'd2, LUSE = 2'd3} state_e;

  state_e        state_q, state_d;
  logic [NR-1:0] vld_q, vld_d;
  logic          br_ev, luse_ev;
  logic          pc_en;
  logic [NR-1:0] en;

  // A branch only counts if the instruction claiming it is real.
  assign br_ev   = i_branch_taken & vld_q[BR_STAGE-1];
  // r0 is hardwired zero, so a load into it never creates a dependency.
  assign luse_ev = vld_q[1] & vld_q[0] & i_idex_memread & (i_idex_rt != '0) &
                   ((i_idex_rt == i_ifid_rs) | (i_idex_rt == i_ifid_rt));

  always_comb begin
    state_d = RUN;
    pc_en   = 1'b1;
    en      = '1;
    vld_d   = {vld_q[NR-2:0], 1'b1};
    if (i_dmiss) begin
      state_d = DSTALL;
      pc_en   = 1'b0;
      en      = '0;
      vld_d   = vld_q;
    end else if (br_ev) begin
      // Everything younger than the branch is on the wrong path.
      state_d = RUN;
      for (int k = 0; k < BR_STAGE; k++) vld_d[k] = 1'b0;
    end else if (i_imiss) begin
      state_d  = ISTALL;
      pc_en    = 1'b0;
      vld_d[0] = 1'b0;
    end else if (luse_ev) begin
      // Hold the dependent instruction in IFID; the bubble drops vld_q[1],
      // so the hazard clears after one cycle.
      state_d  = LUSE;
      pc_en    = 1'b0;
      en[0]    = 1'b0;
      vld_d[0] = vld_q[0];
      vld_d[1] = 1'b0;
    end
    if (rst) begin
      pc_en = 1'b0;
      en    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
    end
  end

  assign o_pc_en = pc_en;
  assign o_en    = en;
  assign o_valid = vld_q;
  assign o_state = state_q;

`ifdef PIPE_HAZARD_STALL_CNT_EN
  logic            imiss_rule, luse_rule;
  logic [CNTW-1:0] icnt_q, icnt_d, dcnt_q, dcnt_d, lcnt_q, lcnt_d;

  assign imiss_rule = ~i_dmiss & ~br_ev & i_imiss;
  assign luse_rule  = ~i_dmiss & ~br_ev & ~i_imiss & luse_ev;

  always_comb begin
    icnt_d = icnt_q;
    dcnt_d = dcnt_q;
    lcnt_d = lcnt_q;
    if (imiss_rule && icnt_q != '1) icnt_d = icnt_q + CNTW'(1);
    if (i_dmiss    && dcnt_q != '1) dcnt_d = dcnt_q + CNTW'(1);
    if (luse_rule  && lcnt_q != '1) lcnt_d = lcnt_q + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      icnt_q <= '0;
      dcnt_q <= '0;
      lcnt_q <= '0;
    end else begin
      icnt_q <= icnt_d;
      dcnt_q <= dcnt_d;
      lcnt_q <= lcnt_d;
    end
  end

  assign o_istall_cnt = icnt_q;
  assign o_dstall_cnt = dcnt_q;
  assign o_luse_cnt   = lcnt_q;
`else
  assign o_istall_cnt = '0;
  assign o_dstall_cnt = '0;
  assign o_luse_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (default parameters), plus a
// second instance with CNTW=2 for counter saturation. Counter expectations
// follow whether PIPE_HAZARD_STALL_CNT_EN is defined for the build.
module tb_pipe_hazard_ctrl;
`ifdef PIPE_HAZARD_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_imiss, i_dmiss, i_branch_taken, i_idex_memread;
  logic [4:0]  i_idex_rt, i_ifid_rs, i_ifid_rt;
  logic        o_pc_en, s_pc_en;
  logic [3:0]  o_en, o_valid, s_en, s_valid;
  logic [1:0]  o_state, s_state;
  logic [15:0] o_istall_cnt, o_dstall_cnt, o_luse_cnt;
  logic [1:0]  s_istall_cnt, s_dstall_cnt, s_luse_cnt;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .i_imiss(i_imiss), .i_dmiss(i_dmiss),
    .i_branch_taken(i_branch_taken), .i_idex_memread(i_idex_memread),
    .i_idex_rt(i_idex_rt), .i_ifid_rs(i_ifid_rs), .i_ifid_rt(i_ifid_rt),
    .o_pc_en(o_pc_en), .o_en(o_en), .o_valid(o_valid), .o_state(o_state),
    .o_istall_cnt(o_istall_cnt), .o_dstall_cnt(o_dstall_cnt), .o_luse_cnt(o_luse_cnt)
  );

  pipe_hazard_ctrl #(.CNTW(2)) dut_sat (
    .clk(clk), .rst(rst), .i_imiss(i_imiss), .i_dmiss(i_dmiss),
    .i_branch_taken(i_branch_taken), .i_idex_memread(i_idex_memread),
    .i_idex_rt(i_idex_rt), .i_ifid_rs(i_ifid_rs), .i_ifid_rt(i_ifid_rt),
    .o_pc_en(s_pc_en), .o_en(s_en), .o_valid(s_valid), .o_state(s_state),
    .o_istall_cnt(s_istall_cnt), .o_dstall_cnt(s_dstall_cnt), .o_luse_cnt(s_luse_cnt)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_imiss = 0; i_dmiss = 0; i_branch_taken = 0; i_idex_memread = 0;
    i_idex_rt = 0; i_ifid_rs = 0; i_ifid_rt = 0;
  endtask

  // Reset, then four quiet cycles to fill the pipe to 1111.
  task automatic reset_fill();
    clear_inputs();
    rst = 1;
    step();
    rst = 0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    clear_inputs();
    // Reset must also abort an in-progress dmiss stall.
    rst = 0; i_dmiss = 1;
    step();
    rst = 1; i_imiss = 1; i_branch_taken = 1;
    #1;
    nvec++; if (o_pc_en !== 1'b0) begin nfail++; $display("FAIL rst_pc_en got %b exp 0", o_pc_en); end
    nvec++; if (o_en !== 4'b0000) begin nfail++; $display("FAIL rst_en got %b exp 0000", o_en); end
    step();
    nvec++; if (o_valid !== 4'b0000) begin nfail++; $display("FAIL rst_valid got %b exp 0000", o_valid); end
    nvec++; if (o_state !== 2'd0) begin nfail++; $display("FAIL rst_state got %0d exp 0", o_state); end
    nvec++; if (o_dstall_cnt !== 16'd0) begin nfail++; $display("FAIL rst_dcnt got %0d exp 0", o_dstall_cnt); end
    clear_inputs();
  endtask

  task automatic test_fill();
    logic [3:0] exp_v [5];
    exp_v[0] = 4'b0000; exp_v[1] = 4'b0001; exp_v[2] = 4'b0011;
    exp_v[3] = 4'b0111; exp_v[4] = 4'b1111;
    clear_inputs();
    rst = 1;
    step();
    rst = 0;
    #1;
    for (int i = 0; i < 5; i++) begin
      nvec++; if (o_valid !== exp_v[i]) begin nfail++; $display("FAIL fill_valid%0d got %b exp %b", i, o_valid, exp_v[i]); end
      nvec++; if (o_pc_en !== 1'b1) begin nfail++; $display("FAIL fill_pc_en%0d got %b exp 1", i, o_pc_en); end
      if (i < 4) step();
    end
  endtask

  task automatic test_dmiss();
    reset_fill();
    i_dmiss = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      nvec++; if (o_pc_en !== 1'b0) begin nfail++; $display("FAIL dmiss_pc_en%0d got %b exp 0", i, o_pc_en); end
      nvec++; if (o_en !== 4'b0000) begin nfail++; $display("FAIL dmiss_en%0d got %b exp 0000", i, o_en); end
      step();
      nvec++; if (o_valid !== 4'b1111) begin nfail++; $display("FAIL dmiss_valid%0d got %b exp 1111", i, o_valid); end
      nvec++; if (o_state !== 2'd2) begin nfail++; $display("FAIL dmiss_state%0d got %0d exp 2", i, o_state); end
    end
    nvec++; if (o_dstall_cnt !== (CNT_EN ? 16'd3 : 16'd0)) begin nfail++; $display("FAIL dmiss_cnt got %0d exp %0d", o_dstall_cnt, CNT_EN ? 3 : 0); end
    clear_inputs();
  endtask

  task automatic test_imiss();
    reset_fill();
    i_imiss = 1;
    #1;
    nvec++; if (o_pc_en !== 1'b0) begin nfail++; $display("FAIL imiss_pc_en got %b exp 0", o_pc_en); end
    nvec++; if (o_en !== 4'b1111) begin nfail++; $display("FAIL imiss_en got %b exp 1111", o_en); end
    step();
    nvec++; if (o_valid !== 4'b1110) begin nfail++; $display("FAIL imiss_valid1 got %b exp 1110", o_valid); end
    nvec++; if (o_state !== 2'd1) begin nfail++; $display("FAIL imiss_state got %0d exp 1", o_state); end
    step();
    nvec++; if (o_valid !== 4'b1100) begin nfail++; $display("FAIL imiss_valid2 got %b exp 1100", o_valid); end
    nvec++; if (o_istall_cnt !== (CNT_EN ? 16'd2 : 16'd0)) begin nfail++; $display("FAIL imiss_cnt got %0d exp %0d", o_istall_cnt, CNT_EN ? 2 : 0); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    reset_fill();
    i_idex_memread = 1; i_idex_rt = 5'd5; i_ifid_rs = 5'd5; i_ifid_rt = 5'd7;
    #1;
    nvec++; if (o_en !== 4'b1110) begin nfail++; $display("FAIL luse_en got %b exp 1110", o_en); end
    nvec++; if (o_pc_en !== 1'b0) begin nfail++; $display("FAIL luse_pc_en got %b exp 0", o_pc_en); end
    step();
    nvec++; if (o_valid !== 4'b1101) begin nfail++; $display("FAIL luse_valid got %b exp 1101", o_valid); end
    nvec++; if (o_state !== 2'd3) begin nfail++; $display("FAIL luse_state got %0d exp 3", o_state); end
    nvec++; if (o_luse_cnt !== (CNT_EN ? 16'd1 : 16'd0)) begin nfail++; $display("FAIL luse_cnt got %0d exp %0d", o_luse_cnt, CNT_EN ? 1 : 0); end
    // Same operands still present, but the IDEX bubble ends the stall.
    nvec++; if (o_en !== 4'b1111) begin nfail++; $display("FAIL luse_release_en got %b exp 1111", o_en); end
    // rt = 0 never stalls.
    reset_fill();
    i_idex_memread = 1; i_idex_rt = 5'd0; i_ifid_rs = 5'd0; i_ifid_rt = 5'd0;
    #1;
    nvec++; if (o_en !== 4'b1111) begin nfail++; $display("FAIL luse_r0_en got %b exp 1111", o_en); end
    nvec++; if (o_pc_en !== 1'b1) begin nfail++; $display("FAIL luse_r0_pc_en got %b exp 1", o_pc_en); end
    step();
    nvec++; if (o_state !== 2'd0) begin nfail++; $display("FAIL luse_r0_state got %0d exp 0", o_state); end
    clear_inputs();
  endtask

  task automatic test_branch();
    reset_fill();
    i_branch_taken = 1; i_imiss = 1;
    #1;
    nvec++; if (o_pc_en !== 1'b1) begin nfail++; $display("FAIL br_pc_en got %b exp 1", o_pc_en); end
    nvec++; if (o_en !== 4'b1111) begin nfail++; $display("FAIL br_en got %b exp 1111", o_en); end
    step();
    nvec++; if (o_valid !== 4'b1000) begin nfail++; $display("FAIL br_valid got %b exp 1000", o_valid); end
    nvec++; if (o_state !== 2'd0) begin nfail++; $display("FAIL br_state got %0d exp 0", o_state); end
    reset_fill();
    i_branch_taken = 1; i_imiss = 1; i_dmiss = 1;
    #1;
    nvec++; if (o_pc_en !== 1'b0) begin nfail++; $display("FAIL br_dmiss_pc_en got %b exp 0", o_pc_en); end
    step();
    nvec++; if (o_valid !== 4'b1111) begin nfail++; $display("FAIL br_dmiss_valid got %b exp 1111", o_valid); end
    nvec++; if (o_state !== 2'd2) begin nfail++; $display("FAIL br_dmiss_state got %0d exp 2", o_state); end
    clear_inputs();
  endtask

  task automatic test_saturation();
    reset_fill();
    i_dmiss = 1;
    repeat (6) step();
    nvec++; if (s_dstall_cnt !== (CNT_EN ? 2'd3 : 2'd0)) begin nfail++; $display("FAIL sat_cnt got %0d exp %0d", s_dstall_cnt, CNT_EN ? 3 : 0); end
    nvec++; if (o_dstall_cnt !== (CNT_EN ? 16'd6 : 16'd0)) begin nfail++; $display("FAIL sat_wide_cnt got %0d exp %0d", o_dstall_cnt, CNT_EN ? 6 : 0); end
    nvec++; if (s_valid !== 4'b1111) begin nfail++; $display("FAIL sat_valid got %b exp 1111", s_valid); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    #1;
    test_reset();
    test_fill();
    test_dmiss();
    test_imiss();
    test_load_use();
    test_branch();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
